avalon_mm_arbiter2: RTL and testbench

Two-master round-robin arbiter that shares one Avalon-MM slave register file: 4-bit address, 32-bit data, one read and one write strobe, fixed read latency. Each master side presents an Avalon-MM master interface with waitrequest/readdatavalid. The arbiter serialises the two masters' accesses, issues one slave transaction at a time, and routes read data back to the requester. It sits between two Qsys masters (e.g. CPU and DMA) and a single slave register block.

---
 rtl/avalon_arb_pkg.sv | 19 +
 rtl/rr_arbiter2.sv | 26 ++
 rtl/avalon_mm_arbiter2.sv | 149 ++++++++++++++
 tb/tb_avalon_mm_arbiter2.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_arb_pkg.sv
// Shared types and defaults for the two-master Avalon-MM arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package avalon_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2
  } state_t;

  typedef logic mst_idx_t;

  localparam int ADDR_W_DEF       = 4;
  localparam int DATA_W_DEF       = 32;
  localparam int READ_LATENCY_DEF = 1;
  localparam int CNT_W            = 3;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: combinational one-hot grant plus next pointer.
// Latency: combinational, zero cycles.
// Backpressure: none; grant is only a function of the current requests.
module rr_arbiter2
  import avalon_arb_pkg::*;
(
  input  logic [1:0] req,
  input  mst_idx_t   ptr,
  input  logic       adv,
  output logic [1:0] gnt,
  output mst_idx_t   ptr_nxt
);

  always_comb begin
    gnt     = req;
    ptr_nxt = ptr;
    if (req == 2'b11) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end
    // after a grant the pointer favours whichever master lost
    if (adv && (gnt != 2'b00)) begin
      ptr_nxt = gnt[0];
    end
  end

endmodule

// File: rtl/avalon_mm_arbiter2.sv
// Two-master round-robin arbiter onto one fixed-latency Avalon-MM slave; ARB_LOCK_EN adds grant locking.
// Latency: request seen in IDLE -> slave strobe next cycle; read data READ_LATENCY+1 after strobe.
// Backpressure: waitrequest stays high except for the single accept (ISSUE) cycle of the winner.
module avalon_mm_arbiter2
  import avalon_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int READ_LATENCY = READ_LATENCY_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
`ifdef ARB_LOCK_EN
  input  logic              m0_lock,
  input  logic              m1_lock,
`endif
  output logic [ADDR_W-1:0] s_address,
  output logic              s_read,
  output logic              s_write,
  output logic [DATA_W-1:0] s_writedata,
  input  logic [DATA_W-1:0] s_readdata
);

  state_t            state, state_nxt;
  mst_idx_t          ptr, ptr_nxt, win;
  logic [1:0]        req, gnt;
  logic              adv, sel_rd, sel_wr, sel_lock;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [CNT_W-1:0]  cnt;

  assign req       = {m1_read | m1_write, m0_read | m0_write};
  assign sel_rd    = gnt[1] ? m1_read      : m0_read;
  assign sel_wr    = gnt[1] ? m1_write     : m0_write;
  assign sel_addr  = gnt[1] ? m1_address   : m0_address;
  assign sel_wdata = gnt[1] ? m1_writedata : m0_writedata;

`ifdef ARB_LOCK_EN
  logic lock_hold;
  assign sel_lock = gnt[1] ? m1_lock : m0_lock;
`else
  assign sel_lock = 1'b0;
`endif

  assign adv = (state == IDLE) && !sel_lock;

  rr_arbiter2 u_rr (
    .req     (req),
    .ptr     (ptr),
    .adv     (adv),
    .gnt     (gnt),
    .ptr_nxt (ptr_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req != 2'b00) state_nxt = ISSUE;
      ISSUE:   state_nxt = s_read ? RDWAIT : IDLE;
      RDWAIT:  if (cnt == CNT_W'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr              <= 1'b0;
      win              <= 1'b0;
      cnt              <= '0;
      s_address        <= '0;
      s_writedata      <= '0;
      s_read           <= 1'b0;
      s_write          <= 1'b0;
      m0_waitrequest   <= 1'b1;
      m1_waitrequest   <= 1'b1;
      m0_readdata      <= '0;
      m1_readdata      <= '0;
      m0_readdatavalid <= 1'b0;
      m1_readdatavalid <= 1'b0;
`ifdef ARB_LOCK_EN
      lock_hold        <= 1'b0;
`endif
    end else begin
      m0_readdatavalid <= 1'b0;
      m1_readdatavalid <= 1'b0;
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            win            <= gnt[1];
            ptr            <= sel_lock ? gnt[1] : ptr_nxt;
            s_address      <= sel_addr;
            s_writedata    <= sel_wdata;
            // a write wins over a simultaneous read from the same master
            s_write        <= sel_wr;
            s_read         <= sel_rd & ~sel_wr;
            m0_waitrequest <= ~gnt[0];
            m1_waitrequest <= ~gnt[1];
`ifdef ARB_LOCK_EN
            lock_hold      <= sel_lock;
          end else if (lock_hold) begin
            ptr            <= ~ptr;
            lock_hold      <= 1'b0;
`endif
          end
        end
        ISSUE: begin
          s_read         <= 1'b0;
          s_write        <= 1'b0;
          m0_waitrequest <= 1'b1;
          m1_waitrequest <= 1'b1;
          cnt            <= CNT_W'(READ_LATENCY);
        end
        RDWAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            if (win) begin
              m1_readdata      <= s_readdata;
              m1_readdatavalid <= 1'b1;
            end else begin
              m0_readdata      <= s_readdata;
              m0_readdatavalid <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_avalon_mm_arbiter2.sv
// Randomised and directed scoreboard bench for avalon_mm_arbiter2 with a fixed-latency slave memory.
// Latency: n/a. Backpressure: masters hold each command until they see waitrequest low.
module tb_avalon_mm_arbiter2;
  localparam int RL = 3;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] data;
  } cmd_t;

  typedef struct {
    int          m;
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic [31:0] d;
    int          cyc;
  } rsp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  m0_address = '0, m1_address = '0;
  logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
  logic [31:0] m0_writedata = '0, m1_writedata = '0;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic [3:0]  s_address;
  logic        s_read, s_write;
  logic [31:0] s_writedata, s_readdata;
`ifdef ARB_LOCK_EN
  logic m0_lock = 1'b0, m1_lock = 1'b0;
`endif

  avalon_mm_arbiter2 #(.ADDR_W(4), .DATA_W(32), .READ_LATENCY(RL)) dut (
    .clk              (clk),
    .reset            (reset),
    .m0_address       (m0_address),
    .m0_read          (m0_read),
    .m0_write         (m0_write),
    .m0_writedata     (m0_writedata),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (m1_address),
    .m1_read          (m1_read),
    .m1_write         (m1_write),
    .m1_writedata     (m1_writedata),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
`ifdef ARB_LOCK_EN
    .m0_lock          (m0_lock),
    .m1_lock          (m1_lock),
`endif
    .s_address        (s_address),
    .s_read           (s_read),
    .s_write          (s_write),
    .s_writedata      (s_writedata),
    .s_readdata       (s_readdata)
  );

  // slave register file returning data RL cycles after the read strobe
  logic [31:0] smem [16];
  logic [31:0] pipe [RL];
  always @(posedge clk) begin
    if (s_write) smem[s_address] <= s_writedata;
    pipe[0] <= s_read ? smem[s_address] : 32'hBAD0_BAD0;
    for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
  end
  assign s_readdata = pipe[RL-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;
  exp_t exp_q[$];
  rsp_t rq0[$], rq1[$];
  logic [31:0] ref_mem [16];
  logic [31:0] hold0 = '0, hold1 = '0;
  int pref = 0;
  int start_cyc = 0, prev_cyc = 0, rdv_cnt = 0;
  bit have_prev = 0, prev_rd = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic cmd_t mk(input logic rd, input logic wr, input logic [3:0] a, input logic [31:0] d);
    cmd_t c;
    c.rd = rd; c.wr = wr; c.addr = a; c.data = d;
    return c;
  endfunction

  task automatic drv0(input bit act, input cmd_t c);
    m0_read = act & c.rd; m0_write = act & c.wr;
    m0_address = act ? c.addr : 4'h0; m0_writedata = act ? c.data : 32'h0;
  endtask

  task automatic drv1(input bit act, input cmd_t c);
    m1_read = act & c.rd; m1_write = act & c.wr;
    m1_address = act ? c.addr : 4'h0; m1_writedata = act ? c.data : 32'h0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_m0_waitrequest"}, 32'(m0_waitrequest), 32'd1);
    chk({tag, "_m1_waitrequest"}, 32'(m1_waitrequest), 32'd1);
    chk({tag, "_m0_rdv"}, 32'(m0_readdatavalid), 32'd0);
    chk({tag, "_m1_rdv"}, 32'(m1_readdatavalid), 32'd0);
    chk({tag, "_m0_readdata"}, m0_readdata, 32'd0);
    chk({tag, "_m1_readdata"}, m1_readdata, 32'd0);
    chk({tag, "_s_read"}, 32'(s_read), 32'd0);
    chk({tag, "_s_write"}, 32'(s_write), 32'd0);
    chk({tag, "_s_address"}, 32'(s_address), 32'd0);
    chk({tag, "_s_writedata"}, s_writedata, 32'd0);
  endtask

  // Both masters stay backlogged: grants alternate while both have work, the
  // pointer always moving to the loser; a lone master takes every slot.
  task automatic run_phase(input cmd_t c0[$], input cmd_t c1[$]);
    int i = 0, j = 0, pick, n = 0;
    cmd_t c;
    exp_t e;
    bit a0, a1;
    while (i < c0.size() || j < c1.size()) begin
      if (i < c0.size() && j < c1.size()) pick = pref;
      else pick = (i < c0.size()) ? 0 : 1;
      if (pick == 0) begin c = c0[i]; i++; end
      else begin c = c1[j]; j++; end
      e.m = pick; e.wr = c.wr; e.addr = c.addr;
      if (c.wr) begin ref_mem[c.addr] = c.data; e.data = c.data; end
      else e.data = ref_mem[c.addr];
      exp_q.push_back(e);
      pref = 1 - pick;
    end
    @(posedge clk); #1;
    have_prev = 0; start_cyc = cyc;
    i = 0; j = 0;
    drv0(c0.size() > 0, (c0.size() > 0) ? c0[0] : mk(0, 0, 0, 0));
    drv1(c1.size() > 0, (c1.size() > 0) ? c1[0] : mk(0, 0, 0, 0));
    while (i < c0.size() || j < c1.size()) begin
      @(negedge clk);
      a0 = !m0_waitrequest; a1 = !m1_waitrequest;
      @(posedge clk); #1;
      if (a0) i++;
      if (a1) j++;
      drv0(i < c0.size(), (i < c0.size()) ? c0[i] : mk(0, 0, 0, 0));
      drv1(j < c1.size(), (j < c1.size()) ? c1[j] : mk(0, 0, 0, 0));
      n++;
      if (n > 1000) begin
        chk("accept_timeout", 32'(i + j), 32'(c0.size() + c1.size()));
        break;
      end
    end
    drv0(0, mk(0, 0, 0, 0)); drv1(0, mk(0, 0, 0, 0));
    n = 0;
    while ((exp_q.size() + rq0.size() + rq1.size()) != 0 && n < 100) begin
      @(posedge clk); n++;
    end
    chk("drain_outstanding", 32'(exp_q.size() + rq0.size() + rq1.size()), 32'd0);
    repeat (2) @(posedge clk);
  endtask

  // monitor: slave-side issues and read responses against the scoreboard
  initial begin
    exp_t e;
    rsp_t r;
    int m, ec;
    forever begin
      @(negedge clk);
      if (s_read || s_write) begin
        m = !m0_waitrequest ? 0 : (!m1_waitrequest ? 1 : 2);
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_issue addr=%h write=%0d expected no transaction", s_address, s_write);
        end else begin
          e = exp_q.pop_front();
          chk("grant_master", 32'(m), 32'(e.m));
          chk("waitrequest_onehot", 32'(int'(m0_waitrequest) + int'(m1_waitrequest)), 32'd1);
          chk("s_write", 32'(s_write), 32'(e.wr));
          chk("s_read", 32'(s_read), 32'(!e.wr));
          chk("s_address", 32'(s_address), 32'(e.addr));
          if (e.wr) chk("s_writedata", s_writedata, e.data);
          ec = have_prev ? prev_cyc + (prev_rd ? RL + 2 : 2) : start_cyc + 1;
          chk("issue_cycle", 32'(cyc), 32'(ec));
          have_prev = 1; prev_cyc = cyc; prev_rd = !e.wr;
          if (!e.wr) begin
            r.d = e.data; r.cyc = cyc + RL + 1;
            if (e.m == 0) rq0.push_back(r); else rq1.push_back(r);
          end
        end
      end
      if (m0_readdatavalid) begin
        rdv_cnt++;
        if (rq0.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_rdv0 data=%h expected no response", m0_readdata);
        end else begin
          r = rq0.pop_front();
          chk("m0_readdata", m0_readdata, r.d);
          chk("m0_rdv_cycle", 32'(cyc), 32'(r.cyc));
          hold0 = r.d;
          chk("m1_readdata_untouched", m1_readdata, hold1);
        end
      end
      if (m1_readdatavalid) begin
        rdv_cnt++;
        if (rq1.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_rdv1 data=%h expected no response", m1_readdata);
        end else begin
          r = rq1.pop_front();
          chk("m1_readdata", m1_readdata, r.d);
          chk("m1_rdv_cycle", 32'(cyc), 32'(r.cyc));
          hold1 = r.d;
          chk("m0_readdata_untouched", m0_readdata, hold0);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout cycle=%0d required finish earlier", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_t q0[$], q1[$];
    exp_t e;
    int n;
    for (int i = 0; i < 16; i++) begin smem[i] = '0; ref_mem[i] = '0; end
    for (int i = 0; i < RL; i++) pipe[i] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("in_reset");
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_reset_vals("after_reset");

    // simultaneous write/read to the same address: m0 first, m1 reads it back
    q0 = {mk(0, 1, 4'd3, 32'hDEADBEEF)}; q1 = {mk(1, 0, 4'd3, 32'h0)};
    run_phase(q0, q1);

    // both masters streaming writes alternate
    q0 = {}; q1 = {};
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(0, 1, 4'(i), 32'h1));
      q1.push_back(mk(0, 1, 4'(i + 8), 32'h2));
    end
    run_phase(q0, q1);

    // lone read; m0 side must stay untouched
    q0 = {}; q1 = {mk(1, 0, 4'd8, 32'h0)};
    run_phase(q0, q1);

    // read and write together: only the write reaches the slave
    q0 = {mk(1, 1, 4'd5, 32'hA5A5A5A5)}; q1 = {};
    run_phase(q0, q1);
    q0 = {}; q1 = {mk(1, 0, 4'd5, 32'h0)};
    run_phase(q0, q1);

    for (int r = 0; r < 5; r++) begin
      q0 = {}; q1 = {};
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        logic w;
        w = 1'($urandom_range(0, 1));
        q0.push_back(mk(!w, w, 4'($urandom_range(0, 15)), $urandom));
      end
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) begin
        logic w;
        w = 1'($urandom_range(0, 1));
        q1.push_back(mk(!w, w, 4'($urandom_range(0, 15)), $urandom));
      end
      run_phase(q0, q1);
    end

    // reset while a read waits for slave data: response must be discarded
    e.m = 0; e.wr = 0; e.addr = 4'd3; e.data = ref_mem[3];
    exp_q.push_back(e);
    @(posedge clk); #1;
    have_prev = 0; start_cyc = cyc;
    m0_read = 1'b1; m0_address = 4'd3;
    n = 0;
    @(negedge clk);
    while (m0_waitrequest && n < 50) begin @(negedge clk); n++; end
    chk("abort_read_accepted", 32'(m0_waitrequest), 32'd0);
    @(posedge clk); #1;
    m0_read = 1'b0; m0_address = 4'd0;
    reset = 1'b1;
    rq0.delete(); rq1.delete();
    rdv_cnt = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    pref = 0; hold0 = '0; hold1 = '0;
    check_reset_vals("abort");
    repeat (12) @(posedge clk);
    chk("no_rdv_after_abort", 32'(rdv_cnt), 32'd0);

    // after reset the pointer is back on master 0
    q0 = {mk(0, 1, 4'd9, 32'h0BADF00D)}; q1 = {mk(1, 0, 4'd9, 32'h0)};
    run_phase(q0, q1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
